// File: rtl/ram_6502_arb.sv
// Single-array RAM shared by a 6502 core (port A) and the N64/PIF side (port B).
// Round-robin arbitration, pipelined reads with per-port valid, hardware clear after reset.
module ram_6502_arb #(
   parameter int DATA_W         = 8,
   parameter int DEPTH          = 2048,
   parameter int ADDR_W         = 11,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic              a_valid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic              b_valid,
   output logic [DATA_W-1:0] b_rdata,
   output logic              init_busy
);

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t            state;
   logic [ADDR_W-1:0] clr_addr;
   logic              last_grant;
   logic              grant_a;
   logic              grant_b;
   logic              acc_go;
   logic              acc_we;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   logic              in_range;
   logic              rd_go;
   logic [DATA_W-1:0] rd_word;
   logic              ret_valid;
   logic              ret_port;
   logic [DATA_W-1:0] ret_data;

   logic [DATA_W-1:0] mem [DEPTH];

   // last_grant = 1 means B was served last, so a conflict goes to A.
   always_comb begin
      grant_a   = a_req & (~b_req | last_grant);
      grant_b   = b_req & ~grant_a;
      a_ack     = grant_a & ~init_busy;
      b_ack     = grant_b & ~init_busy;
      acc_go    = a_ack | b_ack;
      acc_we    = b_ack ? b_we    : a_we;
      acc_addr  = b_ack ? b_addr  : a_addr;
      acc_wdata = b_ack ? b_wdata : a_wdata;
      in_range  = {1'b0, acc_addr} < (ADDR_W+1)'(DEPTH);
      rd_go     = acc_go & ~acc_we;
      rd_word   = in_range ? mem[acc_addr] : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
         init_busy  <= (CLEAR_ON_RESET != 0);
         clr_addr   <= '0;
         last_grant <= 1'b1;
      end else begin
         case (state)
            ST_CLEAR: begin
               if (clr_addr == ADDR_W'(DEPTH - 1)) begin
                  state     <= ST_RUN;
                  init_busy <= 1'b0;
                  clr_addr  <= '0;
               end else begin
                  clr_addr <= clr_addr + 1'b1;
               end
            end
            default: begin
               if (acc_go) last_grant <= b_ack;
            end
         endcase
      end
   end

   // Out-of-range writes are acked but never reach the array.
   always_ff @(posedge clk) begin
      if (init_busy)
         mem[clr_addr] <= '0;
      else if (acc_go && acc_we && in_range)
         mem[acc_addr] <= acc_wdata;
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic              s_valid;
         logic              s_port;
         logic [DATA_W-1:0] s_data;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               s_valid <= 1'b0;
               s_port  <= 1'b0;
               s_data  <= '0;
            end else begin
               s_valid <= rd_go;
               s_port  <= b_ack;
               s_data  <= rd_word;
            end
         end

         assign ret_valid = s_valid;
         assign ret_port  = s_port;
         assign ret_data  = s_data;
      end else begin : g_lat1
         assign ret_valid = rd_go;
         assign ret_port  = b_ack;
         assign ret_data  = rd_word;
      end
   endgenerate

   // Each port keeps its own rdata so the other port's traffic cannot disturb it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_valid <= 1'b0;
         a_rdata <= '0;
         b_valid <= 1'b0;
         b_rdata <= '0;
      end else begin
         a_valid <= ret_valid & ~ret_port;
         b_valid <= ret_valid & ret_port;
         if (ret_valid && !ret_port) a_rdata <= ret_data;
         if (ret_valid && ret_port)  b_rdata <= ret_data;
      end
   end

endmodule

// File: tb/tb_ram_6502_arb.sv
// Directed bench for ram_6502_arb: a default instance (2048 words, latency 1)
// and a 1536-word, latency-2 instance for range and latency corner cases.
module tb_ram_6502_arb;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;

   logic        a_req, a_we, b_req, b_we;
   logic [10:0] a_addr, b_addr;
   logic [7:0]  a_wdata, b_wdata;
   logic        a_ack, a_valid, b_ack, b_valid, init_busy;
   logic [7:0]  a_rdata, b_rdata;

   logic        d2_a_req, d2_a_we, d2_b_req, d2_b_we;
   logic [10:0] d2_a_addr, d2_b_addr;
   logic [7:0]  d2_a_wdata, d2_b_wdata;
   logic        d2_a_ack, d2_a_valid, d2_b_ack, d2_b_valid, d2_init_busy;
   logic [7:0]  d2_a_rdata, d2_b_rdata;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic       req;
      logic       we;
      logic [10:0] addr;
      logic [7:0] wdata;
      logic       exp_ack;
      logic       exp_valid;
      logic [7:0] exp_rdata;
   } vec_t;

   vec_t vecs[10];
   vec_t vecs2[7];

   always #5 clk = ~clk;

   ram_6502_arb dut (
      .clk(clk), .reset_n(reset_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_valid(a_valid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_valid(b_valid), .b_rdata(b_rdata),
      .init_busy(init_busy)
   );

   ram_6502_arb #(.DEPTH(1536), .READ_LATENCY(2)) dut2 (
      .clk(clk), .reset_n(reset_n),
      .a_req(d2_a_req), .a_we(d2_a_we), .a_addr(d2_a_addr), .a_wdata(d2_a_wdata),
      .a_ack(d2_a_ack), .a_valid(d2_a_valid), .a_rdata(d2_a_rdata),
      .b_req(d2_b_req), .b_we(d2_b_we), .b_addr(d2_b_addr), .b_wdata(d2_b_wdata),
      .b_ack(d2_b_ack), .b_valid(d2_b_valid), .b_rdata(d2_b_rdata),
      .init_busy(d2_init_busy)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one vector on port A of the chosen instance at the falling edge, then settle.
   task automatic applyStimulus(input bit second, input vec_t v);
      @(negedge clk);
      if (second) begin
         d2_a_req = v.req; d2_a_we = v.we; d2_a_addr = v.addr; d2_a_wdata = v.wdata;
      end else begin
         a_req = v.req; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
      end
      #1;
   endtask

   task automatic idleAll();
      a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
      b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
      d2_a_req = 0; d2_a_we = 0; d2_a_addr = '0; d2_a_wdata = '0;
      d2_b_req = 0; d2_b_we = 0; d2_b_addr = '0; d2_b_wdata = '0;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int busy, busy2, early, seen, nz, noack, a_cnt, b_cnt, na, nb;

      vecs[0] = '{1'b1, 1'b1, 11'h123, 8'h5A, 1'b1, 1'b0, 8'h00};
      vecs[1] = '{1'b1, 1'b0, 11'h123, 8'h00, 1'b1, 1'b0, 8'h00};
      vecs[2] = '{1'b1, 1'b1, 11'h7FF, 8'hC3, 1'b1, 1'b1, 8'h5A};
      vecs[3] = '{1'b1, 1'b0, 11'h7FF, 8'h00, 1'b1, 1'b0, 8'h5A};
      vecs[4] = '{1'b1, 1'b0, 11'h000, 8'h00, 1'b1, 1'b1, 8'hC3};
      vecs[5] = '{1'b0, 1'b0, 11'h000, 8'h00, 1'b0, 1'b1, 8'h00};
      vecs[6] = '{1'b0, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 8'h00};
      vecs[7] = '{1'b1, 1'b1, 11'h000, 8'h11, 1'b1, 1'b0, 8'h00};
      vecs[8] = '{1'b1, 1'b0, 11'h000, 8'h00, 1'b1, 1'b0, 8'h00};
      vecs[9] = '{1'b0, 1'b0, 11'h000, 8'h00, 1'b0, 1'b1, 8'h11};

      vecs2[0] = '{1'b1, 1'b1, 11'd1600, 8'hFF, 1'b1, 1'b0, 8'h00};
      vecs2[1] = '{1'b1, 1'b1, 11'd1535, 8'h3C, 1'b1, 1'b0, 8'h00};
      vecs2[2] = '{1'b1, 1'b0, 11'd1535, 8'h00, 1'b1, 1'b0, 8'h00};
      vecs2[3] = '{1'b1, 1'b0, 11'd1600, 8'h00, 1'b1, 1'b0, 8'h00};
      vecs2[4] = '{1'b0, 1'b0, 11'd0,    8'h00, 1'b0, 1'b1, 8'h3C};
      vecs2[5] = '{1'b0, 1'b0, 11'd0,    8'h00, 1'b0, 1'b1, 8'h00};
      vecs2[6] = '{1'b0, 1'b0, 11'd0,    8'h00, 1'b0, 1'b0, 8'h00};

      idleAll();
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      checkOutput("reset_init_busy", 32'(init_busy), 32'd1);
      checkOutput("reset_a_valid", 32'(a_valid), 32'd0);
      checkOutput("reset_a_rdata", 32'(a_rdata), 32'd0);
      checkOutput("reset_b_valid", 32'(b_valid), 32'd0);

      // Hold a read on A through the whole clear; it must not be acked early.
      a_req = 1; a_we = 0; a_addr = 11'd5;
      @(negedge clk);
      reset_n = 1;
      busy = 0; busy2 = 0; early = 0;
      for (int k = 0; k < 5000; k++) begin
         #1;
         if (d2_init_busy) busy2++;
         if (!init_busy) break;
         busy++;
         if (a_ack) early++;
         @(negedge clk);
      end
      checkOutput("clear_len", 32'(busy), 32'd2048);
      checkOutput("clear_len_d2", 32'(busy2), 32'd1536);
      checkOutput("ack_during_clear", 32'(early), 32'd0);
      checkOutput("first_ack_after_clear", 32'(a_ack), 32'd1);
      @(negedge clk);
      a_req = 0;
      #1;
      checkOutput("held_read_valid", 32'(a_valid), 32'd1);
      checkOutput("held_read_data", 32'(a_rdata), 32'd0);

      // Full scan: every word must read back as zero.
      seen = 0; nz = 0; noack = 0;
      for (int i = 0; i <= 2048; i++) begin
         @(negedge clk);
         a_req = (i < 2048); a_we = 0; a_addr = 11'(i);
         #1;
         if (a_valid) begin
            seen++;
            if (a_rdata != 8'h00) nz++;
         end
         if (i < 2048 && !a_ack) noack++;
      end
      a_req = 0;
      checkOutput("scan_valid_count", 32'(seen), 32'd2048);
      checkOutput("scan_nonzero", 32'(nz), 32'd0);
      checkOutput("scan_noack", 32'(noack), 32'd0);

      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, vecs[i]);
         checkOutput($sformatf("vec%0d_ack", i), 32'(a_ack), 32'(vecs[i].exp_ack));
         checkOutput($sformatf("vec%0d_valid", i), 32'(a_valid), 32'(vecs[i].exp_valid));
         checkOutput($sformatf("vec%0d_rdata", i), 32'(a_rdata), 32'(vecs[i].exp_rdata));
         checkOutput($sformatf("vec%0d_b_valid", i), 32'(b_valid), 32'd0);
      end
      a_req = 0;

      // Short array, latency 2: out-of-range write dropped, read returns zero.
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, vecs2[i]);
         checkOutput($sformatf("d2_vec%0d_ack", i), 32'(d2_a_ack), 32'(vecs2[i].exp_ack));
         checkOutput($sformatf("d2_vec%0d_valid", i), 32'(d2_a_valid), 32'(vecs2[i].exp_valid));
         checkOutput($sformatf("d2_vec%0d_rdata", i), 32'(d2_a_rdata), 32'(vecs2[i].exp_rdata));
      end
      d2_a_req = 0;

      // B fills 0x20..0x27 with 0xA0..0xA7, leaving last_grant = B.
      noack = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         b_req = 1; b_we = 1; b_addr = 11'(32'h20 + i); b_wdata = 8'(32'hA0 + i);
         #1;
         if (!b_ack) noack++;
      end
      @(negedge clk);
      b_req = 0; b_we = 0;
      checkOutput("b_write_noack", 32'(noack), 32'd0);

      // Both ports read continuously: grants alternate starting with A.
      a_cnt = 0; b_cnt = 0; na = 0; nb = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         a_req = (a_cnt < 4); a_we = 0; a_addr = 11'(32'h20 + a_cnt);
         b_req = (b_cnt < 4); b_we = 0; b_addr = 11'(32'h24 + b_cnt);
         #1;
         if (k < 8)
            checkOutput($sformatf("rr_ack_%0d", k), 32'({a_ack, b_ack}), (k % 2 == 0) ? 32'd2 : 32'd1);
         if (a_valid) begin
            checkOutput($sformatf("rr_a_data_%0d", na), 32'(a_rdata), 32'(32'hA0 + na));
            na++;
         end
         if (b_valid) begin
            checkOutput($sformatf("rr_b_data_%0d", nb), 32'(b_rdata), 32'(32'hA4 + nb));
            nb++;
         end
         if (a_ack) a_cnt++;
         if (b_ack) b_cnt++;
      end
      idleAll();
      checkOutput("rr_a_count", 32'(na), 32'd4);
      checkOutput("rr_b_count", 32'(nb), 32'd4);

      // Reset is asynchronous: outputs clear without a clock edge.
      @(negedge clk);
      #1 reset_n = 0;
      #1;
      checkOutput("async_a_rdata", 32'(a_rdata), 32'd0);
      checkOutput("async_b_rdata", 32'(b_rdata), 32'd0);
      checkOutput("async_init_busy", 32'(init_busy), 32'd1);
      @(negedge clk);
      reset_n = 1;
      repeat (1000) @(negedge clk);
      #1 reset_n = 0;
      #1;
      checkOutput("midclear_init_busy", 32'(init_busy), 32'd1);
      @(negedge clk);
      reset_n = 1;
      busy = 0;
      for (int k = 0; k < 5000; k++) begin
         #1;
         if (!init_busy) break;
         busy++;
         @(negedge clk);
      end
      checkOutput("rerun_clear_len", 32'(busy), 32'd2048);

      // 0x123 held 0x5A before the reset; the rerun clear must have zeroed it.
      @(negedge clk);
      a_req = 1; a_we = 0; a_addr = 11'h123;
      #1;
      checkOutput("rerun_read_ack", 32'(a_ack), 32'd1);
      @(negedge clk);
      a_req = 0;
      #1;
      checkOutput("rerun_read_valid", 32'(a_valid), 32'd1);
      checkOutput("rerun_read_data", 32'(a_rdata), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
